// File: rtl/axon_pkg.sv
// Shared definitions for the axon systolic array.
//   - Default parameter constants for the top level and the PE cell.
//   - Tile-controller state enumeration.
package axon_pkg;

  localparam int AXON_DATA_WIDTH = 16;
  localparam int AXON_ACC_WIDTH  = 40;
  localparam int AXON_ROWS       = 16;
  localparam int AXON_COLS       = 16;
  localparam int AXON_K_WIDTH    = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } axon_state_e;

endpackage

// File: rtl/axon_pe.sv
// axon_pe: one registered multiply-accumulate cell of the systolic array.
// Ports:
//   clk, rst     - rising-edge clock, synchronous active-high reset
//   clr_i        - clear the accumulator (start of a tile)
//   acc_en_i     - accumulate enable; a product is added only when v_i is also 1
//   v_i, a_i     - token valid and ifmap operand arriving from the left
//   b_i          - weight operand arriving from above
//   v_o, a_o     - registered valid/ifmap passed to the right-hand neighbour
//   b_o          - registered weight passed to the neighbour below
//   acc_o        - current accumulator value
module axon_pe import axon_pkg::*; #(
  parameter int DATA_WIDTH = AXON_DATA_WIDTH,
  parameter int ACC_WIDTH  = AXON_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         acc_en_i,
  input  logic                         v_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic                         v_o,
  output logic signed [DATA_WIDTH-1:0] a_o,
  output logic signed [DATA_WIDTH-1:0] b_o,
  output logic signed [ACC_WIDTH-1:0]  acc_o
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  // Full-precision signed product, sign-extended and added with plain
  // modulo-2^ACC_WIDTH wrap (no saturation).
  function automatic logic signed [ACC_WIDTH-1:0] mac_wrap(
    input logic signed [ACC_WIDTH-1:0]  acc,
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [PROD_W-1:0] prod;
    prod = a * b;
    return acc + ACC_WIDTH'(prod);
  endfunction

  logic signed [DATA_WIDTH-1:0] a_q, b_q;
  logic                         v_q;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (acc_en_i && v_i) begin
      acc_d = mac_wrap(acc_q, a_i, b_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      v_q   <= 1'b0;
      acc_q <= '0;
    end else begin
      a_q   <= a_i;
      b_q   <= b_i;
      v_q   <= v_i;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign v_o   = v_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/axon_systolic_array.sv
// axon_systolic_array: output-stationary ROWS x COLS systolic MAC array.
// A tile is started with start/k_len, fed k_len operand beats (one ifmap
// element per row and one weight element per column), flushed, and then
// drained one accumulator row per accepted out_valid/out_ready handshake.
// Ports:
//   clk, rst              - rising-edge clock, synchronous active-high reset
//   start, k_len          - tile start (sampled in IDLE) and reduction length
//   busy                  - high whenever the controller is not IDLE
//   in_valid, in_ready    - operand beat handshake (in_ready only in LOAD)
//   ifmap_in              - ROWS signed elements, row 0 in the LSBs
//   weight_in             - COLS signed elements, column 0 in the LSBs
//   out_valid, out_ready  - result row handshake
//   out_data              - COLS accumulators of row out_row, column 0 in LSBs
//   out_row               - index of the row on out_data
//   done                  - one-cycle pulse when the last row has been taken
// ROWS and COLS must each be at least 2.
module axon_systolic_array import axon_pkg::*; #(
  parameter int DATA_WIDTH = AXON_DATA_WIDTH,
  parameter int ACC_WIDTH  = AXON_ACC_WIDTH,
  parameter int ROWS       = AXON_ROWS,
  parameter int COLS       = AXON_COLS,
  parameter int K_WIDTH    = AXON_K_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [K_WIDTH-1:0]         k_len,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH*ROWS-1:0] ifmap_in,
  input  logic [DATA_WIDTH*COLS-1:0] weight_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_WIDTH*COLS-1:0]  out_data,
  output logic [$clog2(ROWS)-1:0]    out_row,
  output logic                       done
);

  localparam int ROW_W     = $clog2(ROWS);
  // The last beat needs ROWS+COLS-2 further cycles to reach PE(ROWS-1,COLS-1)
  // and one more edge to be accumulated there.
  localparam int FLUSH_LEN = ROWS + COLS - 1;
  localparam int FL_W      = $clog2(FLUSH_LEN + 1);

  axon_state_e          state_q, state_d;
  logic [K_WIDTH-1:0]   k_len_q, k_len_d;
  logic [K_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic [FL_W-1:0]      flush_cnt_q, flush_cnt_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic                 clr_acc;
  logic                 acc_en;
  logic                 inj_v;

  // ---------------------------------------------------------------------
  // Tile controller
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    row_d       = row_q;
    clr_acc     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        beat_cnt_d  = '0;
        flush_cnt_d = '0;
        row_d       = '0;
        if (start) begin
          clr_acc = 1'b1;
          k_len_d = k_len;
          state_d = (k_len == '0) ? ST_DRAIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          beat_cnt_d = beat_cnt_q + K_WIDTH'(1);
          if (beat_cnt_d == k_len_q) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q + FL_W'(1);
        if (flush_cnt_q == FL_W'(FLUSH_LEN - 1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          row_d = row_q + ROW_W'(1);
          if (row_q == ROW_W'(ROWS - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      row_q       <= row_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);

  // Outside an accepted beat the array still advances with a bubble.
  assign inj_v  = in_ready & in_valid;
  assign acc_en = (state_q == ST_LOAD) || (state_q == ST_FLUSH);

  // ---------------------------------------------------------------------
  // Input skew: row r delayed r cycles, column c delayed c cycles
  // ---------------------------------------------------------------------
  logic signed [DATA_WIDTH-1:0] a_pipe [ROWS][COLS+1];
  logic                         v_pipe [ROWS][COLS+1];
  logic signed [DATA_WIDTH-1:0] b_pipe [ROWS+1][COLS];
  logic signed [ACC_WIDTH-1:0]  acc_arr [ROWS][COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
    logic signed [DATA_WIDTH-1:0] a_in;
    assign a_in = inj_v ? ifmap_in[r*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (r == 0) begin : g_direct
      assign a_pipe[r][0] = a_in;
      assign v_pipe[r][0] = inj_v;
    end else begin : g_chain
      logic signed [DATA_WIDTH-1:0] a_sk_q [r];
      logic                         v_sk_q [r];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < r; i++) begin
            a_sk_q[i] <= '0;
            v_sk_q[i] <= 1'b0;
          end
        end else begin
          a_sk_q[0] <= a_in;
          v_sk_q[0] <= inj_v;
          for (int i = 1; i < r; i++) begin
            a_sk_q[i] <= a_sk_q[i-1];
            v_sk_q[i] <= v_sk_q[i-1];
          end
        end
      end
      assign a_pipe[r][0] = a_sk_q[r-1];
      assign v_pipe[r][0] = v_sk_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col_skew
    logic signed [DATA_WIDTH-1:0] b_in;
    assign b_in = inj_v ? weight_in[c*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (c == 0) begin : g_direct
      assign b_pipe[0][c] = b_in;
    end else begin : g_chain
      logic signed [DATA_WIDTH-1:0] b_sk_q [c];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < c; i++) begin
            b_sk_q[i] <= '0;
          end
        end else begin
          b_sk_q[0] <= b_in;
          for (int i = 1; i < c; i++) begin
            b_sk_q[i] <= b_sk_q[i-1];
          end
        end
      end
      assign b_pipe[0][c] = b_sk_q[c-1];
    end
  end

  // ---------------------------------------------------------------------
  // PE grid: ifmap/valid move right, weights move down, one hop per cycle
  // ---------------------------------------------------------------------
  for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe_col
      axon_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (clr_acc),
        .acc_en_i (acc_en),
        .v_i      (v_pipe[r][c]),
        .a_i      (a_pipe[r][c]),
        .b_i      (b_pipe[r][c]),
        .v_o      (v_pipe[r][c+1]),
        .a_o      (a_pipe[r][c+1]),
        .b_o      (b_pipe[r+1][c]),
        .acc_o    (acc_arr[r][c])
      );
    end
  end

  // ---------------------------------------------------------------------
  // Drain output: row select, zero outside DRAIN
  // ---------------------------------------------------------------------
  always_comb begin
    out_data = '0;
    if (state_q == ST_DRAIN) begin
      for (int c = 0; c < COLS; c++) begin
        out_data[c*ACC_WIDTH +: ACC_WIDTH] = acc_arr[row_q][c];
      end
    end
  end

  assign out_row = (state_q == ST_DRAIN) ? row_q : '0;

endmodule

// File: tb/tb_axon_systolic_array.sv
module tb_axon_systolic_array;

  localparam int DW = 16;
  localparam int AW = 40;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int KW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, start, in_valid, out_ready;
  logic [KW-1:0]   k_len;
  logic [DW*R-1:0] ifmap_in;
  logic [DW*C-1:0] weight_in;
  logic            busy, in_ready, out_valid, done;
  logic [AW*C-1:0] out_data;
  logic [1:0]      out_row;

  int total = 0;
  int bad   = 0;

  axon_systolic_array #(
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW),
    .ROWS       (R),
    .COLS       (C),
    .K_WIDTH    (KW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ifmap_in  (ifmap_in),
    .weight_in (weight_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .done      (done)
  );

  task automatic check_int(string name, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(string name, logic [AW*C-1:0] act, logic [AW*C-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------
  // Reference model: tile phases by cycle count, dot products by sum
  // ---------------------------------------------------------------
  logic signed [AW-1:0] exp_acc [R][C];
  bit   m_load = 0, m_drain = 0, m_done = 0, armed = 0;
  int   m_beats_left = 0, m_flush = 0, exp_row = 0;
  logic [AW*C-1:0] ev;
  logic signed [DW-1:0] av, wv;

  always @(negedge clk) begin
    if (armed) begin
      check_int("ctrl{busy,in_ready,out_valid,done}",
                {busy, in_ready, out_valid, done},
                {(m_load || m_flush > 0 || m_drain || m_done), m_load, m_drain, m_done});
      if (m_drain) begin
        for (int c = 0; c < C; c++) ev[c*AW +: AW] = exp_acc[exp_row][c];
        check_int("out_row", out_row, exp_row);
        check_vec("out_data", out_data, ev);
      end else begin
        check_int("idle_out_row", out_row, 0);
        check_vec("idle_out_data", out_data, '0);
      end
    end
    if (rst) begin
      armed = 1; m_load = 0; m_drain = 0; m_done = 0; m_flush = 0; exp_row = 0;
      for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) exp_acc[r][c] = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_load) begin
      if (in_valid) begin
        for (int r = 0; r < R; r++) begin
          av = ifmap_in[r*DW +: DW];
          for (int c = 0; c < C; c++) begin
            wv = weight_in[c*DW +: DW];
            exp_acc[r][c] = exp_acc[r][c] + AW'(longint'(av) * longint'(wv));
          end
        end
        m_beats_left--;
        if (m_beats_left == 0) begin
          m_load = 0;
          m_flush = R + C - 1;
        end
      end
    end else if (m_flush > 0) begin
      m_flush--;
      if (m_flush == 0) begin m_drain = 1; exp_row = 0; end
    end else if (m_drain) begin
      if (out_ready) begin
        exp_row++;
        if (exp_row == R) begin m_drain = 0; m_done = 1; exp_row = 0; end
      end
    end else if (start) begin
      for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) exp_acc[r][c] = '0;
      if (k_len == '0) begin m_drain = 1; exp_row = 0; end
      else begin m_load = 1; m_beats_left = int'(k_len); end
    end
  end

  // ---------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------
  logic signed [DW-1:0] bA [3][R];
  logic signed [DW-1:0] bW [3][C];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(int k, int a0, int a1, int a2, int a3,
                          int w0, int w1, int w2, int w3);
    bA[k][0] = DW'(a0); bA[k][1] = DW'(a1); bA[k][2] = DW'(a2); bA[k][3] = DW'(a3);
    bW[k][0] = DW'(w0); bW[k][1] = DW'(w1); bW[k][2] = DW'(w2); bW[k][3] = DW'(w3);
  endtask

  task automatic do_start(int k);
    int n = 0;
    tick();
    while (busy && n < 3000) begin tick(); n++; end
    if (busy) check_int("start_wait_timeout", 1, 0);
    start = 1'b1;
    k_len = KW'(k);
    tick();
    start = 1'b0;
  endtask

  // gap idle cycles (with junk operands) before every odd beat; a start
  // pulse rides along with beat start_at
  task automatic load_beats(int n, int gap, int start_at);
    for (int i = 0; i < n; i++) begin
      if (gap > 0 && i % 2 == 1) begin
        in_valid = 1'b0;
        ifmap_in = {R{16'h7777}};
        weight_in = {C{16'h5555}};
        repeat (gap) tick();
      end
      for (int r = 0; r < R; r++) ifmap_in[r*DW +: DW] = bA[i % 3][r];
      for (int c = 0; c < C; c++) weight_in[c*DW +: DW] = bW[i % 3][c];
      in_valid = 1'b1;
      start = (i == start_at);
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_tile(int stall_row, int stall_n,
                            logic signed [AW-1:0] lit0, logic signed [AW-1:0] litl,
                            bit junk_in);
    int n = 0, acc_rows = 0, stalls = 0;
    bit got_done = 0;
    logic [AW*C-1:0] held;
    logic signed [AW-1:0] e;
    out_ready = 1'b0;
    while (n < 3000 && !got_done) begin
      if (junk_in) begin
        in_valid = 1'b1;
        ifmap_in = {R{16'h1234}};
        weight_in = {C{16'h0f0f}};
      end
      tick();
      n++;
      if (acc_rows == R) begin
        check_int("done_pulse", done, 1);
        got_done = 1;
      end else if (done) begin
        check_int("done_early_rows", acc_rows, R);
        got_done = 1;
      end else if (out_valid) begin
        if (int'(out_row) == stall_row && stalls < stall_n) begin
          if (stalls > 0) begin
            check_int("stall_row_hold", out_row, stall_row);
            check_vec("stall_data_hold", out_data, held);
          end
          held = out_data;
          stalls++;
          out_ready = 1'b0;
        end else begin
          check_int("row_order", out_row, acc_rows);
          if (out_row == 2'd0) begin
            e = out_data[0 +: AW];
            check_int("lit_r0c0", longint'(e), longint'(lit0));
          end
          if (out_row == 2'(R - 1)) begin
            e = out_data[(C-1)*AW +: AW];
            check_int("lit_rlast_clast", longint'(e), longint'(litl));
          end
          out_ready = 1'b1;
          acc_rows++;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
    if (!got_done) check_int("drain_timeout", 1, 0);
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b0;
    ifmap_in = '0; weight_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_int("reset_ctrl", {busy, in_ready, out_valid, done, out_row}, 0);
    check_vec("reset_data", out_data, '0);

    // all-2 by all-3, one beat: every element 6
    set_beat(0, 2, 2, 2, 2, 3, 3, 3, 3);
    do_start(1);
    load_beats(1, 0, -1);
    drain_tile(-1, 0, 40'sd6, 40'sd6, 0);

    // back-to-back start, mixed-sign dot products with gaps, stall on row 1
    set_beat(0, 3, -2, 5, 100, 2, -5, 1, 7);
    set_beat(1, -7, 4, 0, -1, 3, 0, -2, 1);
    set_beat(2, 1, 1, -3, 2, -4, 6, 9, -1);
    do_start(3);
    load_beats(3, 2, -1);
    drain_tile(1, 5, -40'sd19, 40'sd697, 0);

    // start pulsed during LOAD is ignored
    set_beat(0, 1, 2, 3, 4, 5, 6, 7, 8);
    set_beat(1, -1, -1, -1, -1, 1, 1, 1, 1);
    do_start(2);
    load_beats(2, 1, 1);
    drain_tile(-1, 0, 40'sd4, 40'sd31, 0);

    // k_len = 0 drains zeros; in_valid outside LOAD is ignored
    do_start(0);
    drain_tile(-1, 0, 40'sd0, 40'sd0, 1);

    // wrap: 1023 * (-32768)^2 = 1023*2^30 mod 2^40 = -2^30
    set_beat(0, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
    set_beat(1, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
    set_beat(2, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
    do_start(1023);
    load_beats(1023, 0, -1);
    drain_tile(-1, 0, -40'sd1073741824, -40'sd1073741824, 0);

    // reset mid-FLUSH aborts the tile
    set_beat(0, 9, 9, 9, 9, 9, 9, 9, 9);
    do_start(1);
    load_beats(1, 0, -1);
    tick();
    tick();
    check_int("in_flush_busy", {busy, in_ready, out_valid}, 3'b100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_int("abort_ctrl", {busy, in_ready, out_valid, done, out_row}, 0);
    check_vec("abort_data", out_data, '0);
    repeat (3) begin
      tick();
      check_int("abort_no_done", done, 0);
    end

    // fresh tile after abort: no stale sums
    set_beat(0, 1, 1, 1, 1, 1, 1, 1, 1);
    do_start(1);
    load_beats(1, 0, -1);
    drain_tile(-1, 0, 40'sd1, 40'sd1, 0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axon_systolic_array.md
AXON_SYSTOLIC_ARRAY -- requirements
Module: axon_systolic_array

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed operand width.
REQ-002 SHALL have parameter ACC_WIDTH, default 40, signed accumulator width.
REQ-003 SHALL have parameters ROWS and COLS, each default 16, array dimensions; each SHALL be at least 2.
REQ-004 SHALL have parameter K_WIDTH, default 10, width of the reduction-length field.
REQ-005 SHALL have clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have start, input, 1: begin a tile; sampled only in IDLE.
REQ-008 SHALL have k_len, input, K_WIDTH: reduction length, captured on an accepted start.
REQ-009 SHALL have busy, output, 1: high in every state except IDLE.
REQ-010 SHALL have in_valid, input, 1, and in_ready, output, 1: the operand beat handshake.
REQ-011 SHALL have ifmap_in, input, DATA_WIDTH*ROWS: one ifmap element per row, with row 0 in the LSBs.
REQ-012 SHALL have weight_in, input, DATA_WIDTH*COLS: one weight element per column, with column 0 in the LSBs.
REQ-013 SHALL have out_valid, output, 1, and out_ready, input, 1: the result handshake.
REQ-014 SHALL have out_data, output, ACC_WIDTH*COLS: one accumulator row, with column 0 in the LSBs.
REQ-015 SHALL have out_row, output, clog2(ROWS): the index of the row presented on out_data.
REQ-016 SHALL have done, output, 1: a one-cycle pulse at tile completion.

Function
REQ-017 SHALL implement the states IDLE, LOAD, FLUSH, DRAIN and DONE.
REQ-018 IDLE: start=1 SHALL capture k_len and clear all accumulators, then enter LOAD if k_len is non-zero, else DRAIN.
REQ-019 LOAD: in_ready SHALL be 1; a beat is accepted when in_valid and in_ready are both 1; after beat number k_len is accepted, the next state SHALL be FLUSH.
REQ-020 In LOAD with in_valid=0, the array SHALL still advance, injecting a bubble (token valid=0) into the row and column streams in the same cycle.
REQ-021 Ifmap element r SHALL be delayed r cycles by a skew register chain before PE(r,0); weight element c SHALL be delayed c cycles before PE(0,c).
REQ-022 Each PE SHALL pass its ifmap operand and valid bit right, and its weight operand down, with one register per hop.
REQ-023 PE(r,c) SHALL therefore see beat t at cycle t+r+c.
REQ-024 A PE SHALL accumulate only when its token valid is 1: acc += sign-extended(a*b), where the product is a full 2*DATA_WIDTH-bit signed value.
REQ-025 Accumulation SHALL wrap modulo 2^ACC_WIDTH, with no saturation.
REQ-026 FLUSH SHALL last exactly ROWS+COLS-1 cycles, with in_ready=0 and bubbles injected, then go to DRAIN.
REQ-027 DRAIN: out_valid SHALL be 1, out_row SHALL start at 0, and out_data SHALL carry the accumulators of row out_row.
REQ-028 In DRAIN, out_row SHALL advance only on out_valid and out_ready both being 1; out_data and out_row SHALL be held stable while out_ready=0.
REQ-029 Acceptance of row ROWS-1 SHALL go to DONE; DONE SHALL assert done for one cycle and then return to IDLE.
REQ-030 start SHALL be ignored while busy=1.
REQ-031 in_valid outside LOAD SHALL be ignored.
REQ-032 k_len=0 SHALL produce a drain of all-zero rows.
REQ-033 Back-to-back tiles: start asserted in the cycle after done SHALL be accepted.

Reset
REQ-034 rst=1 SHALL force IDLE and clear all accumulators, skew registers, PE pipeline registers and the beat counter.
REQ-035 During and after reset, busy, in_ready, out_valid, done, out_data and out_row SHALL all be 0.
REQ-036 rst asserted mid-tile, in any state, SHALL abort the tile; no done pulse SHALL follow.

Structure
REQ-037 The shared package axon_pkg SHALL hold the state enumeration and the default-parameter constants.
REQ-038 There SHALL be one sub-module, axon_pe, a registered MAC cell with pass-through ifmap, weight and valid, and with clear and accumulate controls; the top level SHALL generate ROWS*COLS instances of it.

Verification
REQ-039 ROWS=COLS=4, k_len=1, ifmap=all 2, weight=all 3, out_ready=1 -> every element of all 4 rows equals 6; done is asserted in the cycle after row 3 is accepted.
REQ-040 ROWS=COLS=4, k_len=3, random signed operands with random in_valid gaps -> each acc(r,c) equals the reference dot product sum over beats k of A[k][r]*W[k][c].
REQ-041 ifmap=-32768, weight=-32768, k_len=1023, ACC_WIDTH=40 -> each element equals 1023*2^30 modulo 2^40, interpreted as a signed value.
REQ-042 In DRAIN, hold out_ready=0 for 5 cycles on row 1 -> out_row stays 1 and out_data is unchanged; rows are never skipped or repeated.
REQ-043 Assert rst for 1 cycle mid-FLUSH -> the next cycle is IDLE with all outputs 0; a following tile with k_len=1 and operands 1 and 1 yields 1 everywhere, with no stale sums.
REQ-044 start pulsed during LOAD, and k_len=0 in a separate tile -> the first tile is unaffected; the second tile drains zeros, and done fires after ROWS accepted beats.
